alu_arbiter: RTL and testbench

- Shares the single combinational 16-bit integer ALU between two requesters: requester 0 is the integer pipeline and requester 1 is the address/aux unit.
- Owns the architectural flags register (FLGIN source) and updates it from ALU results.
- Arbitrates round-robin, with an optional lock so a requester can issue an uninterrupted ADD/ADDC or SUB/SUBC carry chain.
- Results return one cycle after acceptance on a per-requester response port.

---
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant,
// an optional carry-chain lock with idle timeout, and the architectural flags register.
module alu_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned LOCK_TIMEOUT = 15,
    parameter int unsigned TO_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_lock,
    input  logic [3:0]        req_op0,
    input  logic [3:0]        req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_flgin,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [7:0]        alu_flg,
    input  logic              alu_wb,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data0,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [7:0]        rsp_flags0,
    output logic [7:0]        rsp_flags1,
    output logic [1:0]        rsp_wb,
    output logic [7:0]        flags_q,
    output logic              lock_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lockState_e;

    lockState_e      stateQ, stateD;
    logic            lockOwnerQ, lockOwnerD;
    logic            lastGrantQ, lastGrantD;
    logic [TO_W-1:0] toCntQ, toCntD;
    logic            lockErrD;
    logic [1:0]      grant;
    logic            accept;
    logic            gIdx;

    // Grant: lock owner only while locked, otherwise round-robin on contention
    always_comb begin
        grant = 2'b00;
        if (stateQ == ST_LOCKED) begin
            if (lockOwnerQ) grant[1] = req_valid[1];
            else            grant[0] = req_valid[0];
        end else begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = lastGrantQ ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept    = |grant;
    assign gIdx      = grant[1];
    assign req_ready = grant;
    assign alu_flgin = flags_q;

    // ALU operand mux; idle ALU sees a NOP with zero operands
    always_comb begin
        alu_op = 4'd0;
        alu_a  = '0;
        alu_b  = '0;
        if (grant[0]) begin
            alu_op = req_op0;
            alu_a  = req_a0;
            alu_b  = req_b0;
        end else if (grant[1]) begin
            alu_op = req_op1;
            alu_a  = req_a1;
            alu_b  = req_b1;
        end
    end

    // Lock state, fairness pointer and idle-timeout next state
    always_comb begin
        stateD     = stateQ;
        lockOwnerD = lockOwnerQ;
        lastGrantD = lastGrantQ;
        toCntD     = toCntQ;
        lockErrD   = 1'b0;
        if (accept) begin
            lastGrantD = gIdx;
            toCntD     = '0;
            if (req_lock[gIdx]) begin
                stateD     = ST_LOCKED;
                lockOwnerD = gIdx;
            end else begin
                stateD = ST_UNLOCKED;
            end
        end else if (stateQ == ST_LOCKED) begin
            if (toCntQ == TO_LAST) begin
                stateD     = ST_UNLOCKED;
                toCntD     = '0;
                lockErrD   = 1'b1;
                lastGrantD = lockOwnerQ;
            end else begin
                toCntD = toCntQ + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ     <= ST_UNLOCKED;
            lockOwnerQ <= 1'b0;
            lastGrantQ <= 1'b1;
            toCntQ     <= '0;
            lock_err   <= 1'b0;
        end else begin
            stateQ     <= stateD;
            lockOwnerQ <= lockOwnerD;
            lastGrantQ <= lastGrantD;
            toCntQ     <= toCntD;
            lock_err   <= lockErrD;
        end
    end

    // Response capture and flags register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 2'b00;
            rsp_data0  <= '0;
            rsp_data1  <= '0;
            rsp_flags0 <= 8'h00;
            rsp_flags1 <= 8'h00;
            rsp_wb     <= 2'b00;
            flags_q    <= 8'h00;
        end else begin
            rsp_valid <= grant;
            if (grant[0]) begin
                rsp_data0  <= alu_out;
                rsp_flags0 <= alu_flg;
                rsp_wb[0]  <= alu_wb;
            end
            if (grant[1]) begin
                rsp_data1  <= alu_out;
                rsp_flags1 <= alu_flg;
                rsp_wb[1]  <= alu_wb;
            end
            if (accept && alu_wb) begin
                flags_q <= alu_flg;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU stand-in, per-requester
// response scoreboards, and directed scenario tasks.
module tb_alu_arbiter;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned LOCK_TIMEOUT = 15;
    localparam int unsigned TO_W         = 4;

    logic              clk = 1'b0;
    logic              rstN;
    logic [1:0]        reqValid, reqReady, reqLock;
    logic [3:0]        reqOp0, reqOp1;
    logic [DATA_W-1:0] reqA0, reqB0, reqA1, reqB1;
    logic [3:0]        aluOp;
    logic [DATA_W-1:0] aluA, aluB, aluOut;
    logic [7:0]        aluFlgin, aluFlg;
    logic              aluWb;
    logic [1:0]        rspValid, rspWb;
    logic [DATA_W-1:0] rspData0, rspData1;
    logic [7:0]        rspFlags0, rspFlags1, flagsQ;
    logic              lockErr;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  flags;
        logic        wb;
    } exp_t;

    exp_t       exp0[$];
    exp_t       exp1[$];
    exp_t       monE;
    logic [7:0] mFlags = 8'h00;
    int         nChecks = 0;
    int         nPass = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W), .LOCK_TIMEOUT(LOCK_TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rstN),
        .req_valid(reqValid), .req_ready(reqReady), .req_lock(reqLock),
        .req_op0(reqOp0), .req_op1(reqOp1),
        .req_a0(reqA0), .req_b0(reqB0), .req_a1(reqA1), .req_b1(reqB1),
        .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB), .alu_flgin(aluFlgin),
        .alu_out(aluOut), .alu_flg(aluFlg), .alu_wb(aluWb),
        .rsp_valid(rspValid), .rsp_data0(rspData0), .rsp_data1(rspData1),
        .rsp_flags0(rspFlags0), .rsp_flags1(rspFlags1), .rsp_wb(rspWb),
        .flags_q(flagsQ), .lock_err(lockErr)
    );

    // Behavioural 16-bit ALU: returns {wb, flags, result}
    function automatic logic [24:0] aluModel(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [7:0] fin);
        logic [16:0] full;
        logic [15:0] r;
        logic        c, v, wb;
        full = '0; r = '0; c = 1'b0; v = 1'b0; wb = 1'b1;
        case (op)
            4'd1: begin full = {1'b0, a} + {1'b0, b}; r = full[15:0]; c = full[16];
                        v = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd2: begin full = {1'b0, a} + {1'b0, b} + {16'h0, fin[1]}; r = full[15:0]; c = full[16];
                        v = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd3: begin full = {1'b0, a} - {1'b0, b}; r = full[15:0]; c = full[16];
                        v = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd4: begin full = {1'b0, a} - {1'b0, b} - {16'h0, fin[1]}; r = full[15:0]; c = full[16];
                        v = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd5:  r = a << b[3:0];
            4'd6:  r = a >> b[3:0];
            4'd7:  r = a & b;
            4'd8:  r = a | b;
            4'd9:  r = ~a;
            4'd10: r = a ^ b;
            default: wb = 1'b0;
        endcase
        if (wb) return {1'b1, 4'b0000, r[15], v, c, (r == 16'h0000), r};
        return 25'h0;
    endfunction

    always_comb {aluWb, aluFlg, aluOut} = aluModel(aluOp, aluA, aluB, aluFlgin);

    // Expected result of an op, in the order the bench expects it to be accepted
    task automatic pushExp(input int req, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [24:0] r;
        exp_t        e;
        r = aluModel(op, a, b, mFlags);
        e.data = r[15:0]; e.flags = r[23:16]; e.wb = r[24];
        if (e.wb) mFlags = e.flags;
        if (req == 0) exp0.push_back(e);
        else          exp1.push_back(e);
    endtask

    // Response monitor: pops the scoreboard on every response pulse
    always @(posedge clk) begin
        #2;
        nChecks++;
        if (rspValid === 2'b11) $display("FAIL rsp_onehot rsp_valid=%b want at most one bit", rspValid);
        else nPass++;
        if (rspValid[0] === 1'b1) begin
            nChecks++;
            if (exp0.size() == 0) $display("FAIL rsp0_unexpected data=%h no response expected", rspData0);
            else begin
                monE = exp0.pop_front();
                if ({rspData0, rspFlags0, rspWb[0]} !== monE)
                    $display("FAIL rsp0 got data=%h flags=%h wb=%b want data=%h flags=%h wb=%b",
                             rspData0, rspFlags0, rspWb[0], monE.data, monE.flags, monE.wb);
                else nPass++;
            end
        end
        if (rspValid[1] === 1'b1) begin
            nChecks++;
            if (exp1.size() == 0) $display("FAIL rsp1_unexpected data=%h no response expected", rspData1);
            else begin
                monE = exp1.pop_front();
                if ({rspData1, rspFlags1, rspWb[1]} !== monE)
                    $display("FAIL rsp1 got data=%h flags=%h wb=%b want data=%h flags=%h wb=%b",
                             rspData1, rspFlags1, rspWb[1], monE.data, monE.flags, monE.wb);
                else nPass++;
            end
        end
    end

    task automatic test_reset();
        rstN = 1'b0; reqValid = 2'b00; reqLock = 2'b00;
        reqOp0 = 4'd0; reqOp1 = 4'd0; reqA0 = '0; reqB0 = '0; reqA1 = '0; reqB1 = '0;
        repeat (2) @(negedge clk);
        #1;
        nChecks++;
        if ({rspValid, rspWb, lockErr} !== 5'b0) $display("FAIL reset_ctrl valid=%b wb=%b err=%b want 0", rspValid, rspWb, lockErr);
        else nPass++;
        nChecks++;
        if ({rspData0, rspData1, rspFlags0, rspFlags1} !== 48'h0)
            $display("FAIL reset_data d0=%h d1=%h f0=%h f1=%h want 0", rspData0, rspData1, rspFlags0, rspFlags1);
        else nPass++;
        nChecks++;
        if ({flagsQ, aluFlgin} !== 16'h0) $display("FAIL reset_flags flags_q=%h flgin=%h want 0", flagsQ, aluFlgin);
        else nPass++;
        nChecks++;
        if ({reqReady, aluOp, aluA, aluB} !== 38'h0) $display("FAIL reset_alu_idle ready=%b op=%h a=%h b=%h want 0", reqReady, aluOp, aluA, aluB);
        else nPass++;
        rstN = 1'b1;
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        reqValid = 2'b11; reqLock = 2'b00;
        reqOp0 = 4'd1; reqA0 = 16'd3; reqB0 = 16'd4;
        reqOp1 = 4'd3; reqA1 = 16'd5; reqB1 = 16'd5;
        pushExp(0, 4'd1, 16'd3, 16'd4);
        pushExp(1, 4'd3, 16'd5, 16'd5);
        pushExp(0, 4'd1, 16'd1, 16'd1);
        pushExp(1, 4'd7, 16'hF0F0, 16'hFF00);
        #1; nChecks++;
        if (reqReady !== 2'b01) $display("FAIL rr_first ready=%b want 01", reqReady); else nPass++;
        @(negedge clk);
        reqOp0 = 4'd1; reqA0 = 16'd1; reqB0 = 16'd1;
        #1; nChecks++;
        if (reqReady !== 2'b10) $display("FAIL rr_second ready=%b want 10", reqReady); else nPass++;
        nChecks++;
        if ({rspValid, rspData0} !== {2'b01, 16'd7}) $display("FAIL rr_rsp0 valid=%b data=%h want 01/0007", rspValid, rspData0);
        else nPass++;
        @(negedge clk);
        reqOp1 = 4'd7; reqA1 = 16'hF0F0; reqB1 = 16'hFF00;
        #1; nChecks++;
        if (reqReady !== 2'b01) $display("FAIL rr_third ready=%b want 01", reqReady); else nPass++;
        nChecks++;
        if ({rspValid, rspData1, rspFlags1} !== {2'b10, 16'h0000, 8'h01})
            $display("FAIL rr_rsp1 valid=%b data=%h flags=%h want 10/0000/01", rspValid, rspData1, rspFlags1);
        else nPass++;
        @(negedge clk);
        reqValid = 2'b10;
        #1; nChecks++;
        if (reqReady !== 2'b10) $display("FAIL rr_fourth ready=%b want 10", reqReady); else nPass++;
        @(negedge clk);
        reqValid = 2'b00;
        #1; nChecks++;
        if (reqReady !== 2'b00) $display("FAIL rr_idle ready=%b want 00", reqReady); else nPass++;
        @(negedge clk);
        #1; nChecks++;
        if (flagsQ !== mFlags) $display("FAIL rr_flags flags_q=%h want %h", flagsQ, mFlags); else nPass++;
    endtask

    task automatic test_lock_chain();
        @(negedge clk);
        reqValid = 2'b11; reqLock = 2'b01;
        reqOp0 = 4'd1; reqA0 = 16'hFFFF; reqB0 = 16'h0001;
        reqOp1 = 4'd8; reqA1 = 16'h1234; reqB1 = 16'h0000;
        pushExp(0, 4'd1, 16'hFFFF, 16'h0001);
        #1; nChecks++;
        if (reqReady !== 2'b01) $display("FAIL lock_first ready=%b want 01", reqReady); else nPass++;
        @(negedge clk);
        reqOp0 = 4'd2; reqA0 = 16'h0000; reqB0 = 16'h0000; reqLock = 2'b00;
        pushExp(0, 4'd2, 16'h0000, 16'h0000);
        #1; nChecks++;
        if (reqReady !== 2'b01) $display("FAIL lock_hold ready=%b want 01", reqReady); else nPass++;
        nChecks++;
        if (flagsQ[1] !== 1'b1) $display("FAIL lock_carry flags_q=%h want carry set", flagsQ); else nPass++;
        @(negedge clk);
        reqValid = 2'b10;
        pushExp(1, 4'd8, 16'h1234, 16'h0000);
        #1; nChecks++;
        if (reqReady !== 2'b10) $display("FAIL lock_release ready=%b want 10", reqReady); else nPass++;
        @(negedge clk);
        reqValid = 2'b00;
    endtask

    task automatic test_xor_nop();
        @(negedge clk);
        reqValid = 2'b10; reqLock = 2'b00;
        reqOp1 = 4'd10; reqA1 = 16'hAAAA; reqB1 = 16'hAAAA;
        pushExp(1, 4'd10, 16'hAAAA, 16'hAAAA);
        #1; nChecks++;
        if (reqReady !== 2'b10) $display("FAIL xor_ready ready=%b want 10", reqReady); else nPass++;
        @(negedge clk);
        reqOp1 = 4'd0; reqA1 = 16'd5; reqB1 = 16'd6;
        pushExp(1, 4'd0, 16'd5, 16'd6);
        #1; nChecks++;
        if ({flagsQ, rspWb[1]} !== {8'h01, 1'b1}) $display("FAIL xor_flags flags_q=%h wb1=%b want 01/1", flagsQ, rspWb[1]);
        else nPass++;
        @(negedge clk);
        reqValid = 2'b00;
        #1; nChecks++;
        if ({flagsQ, rspWb[1], rspValid} !== {8'h01, 1'b0, 2'b10})
            $display("FAIL nop_keep flags_q=%h wb1=%b valid=%b want 01/0/10", flagsQ, rspWb[1], rspValid);
        else nPass++;
    endtask

    task automatic test_timeout();
        int blocked;
        int errs;
        logic granted;
        logic errAtGrant;
        @(negedge clk);
        reqValid = 2'b11; reqLock = 2'b01;
        reqOp0 = 4'd7; reqA0 = 16'hFFFF; reqB0 = 16'h00FF;
        reqOp1 = 4'd9; reqA1 = 16'h0000; reqB1 = 16'h0000;
        pushExp(0, 4'd7, 16'hFFFF, 16'h00FF);
        pushExp(1, 4'd9, 16'h0000, 16'h0000);
        #1; nChecks++;
        if (reqReady !== 2'b01) $display("FAIL to_lock ready=%b want 01", reqReady); else nPass++;
        @(negedge clk);
        reqValid = 2'b10; reqLock = 2'b00;
        blocked = 0; errs = 0; granted = 1'b0; errAtGrant = 1'b0;
        for (int i = 0; i < 40 && !granted; i++) begin
            #1;
            if (lockErr === 1'b1) errs++;
            if (reqReady[1] === 1'b1) begin
                granted = 1'b1;
                errAtGrant = lockErr;
            end else begin
                blocked++;
                @(negedge clk);
            end
        end
        nChecks++;
        if (!granted || blocked != int'(LOCK_TIMEOUT))
            $display("FAIL to_blocked granted=%b blocked=%0d want 1/%0d", granted, blocked, LOCK_TIMEOUT);
        else nPass++;
        nChecks++;
        if (errAtGrant !== 1'b1) $display("FAIL to_err_at_grant lock_err=%b want 1", errAtGrant); else nPass++;
        @(negedge clk);
        reqValid = 2'b00;
        #1; if (lockErr === 1'b1) errs++;
        @(negedge clk);
        #1; if (lockErr === 1'b1) errs++;
        nChecks++;
        if (errs != 1) $display("FAIL to_err_pulses count=%0d want 1", errs); else nPass++;
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        reqValid = 2'b11; reqLock = 2'b01;
        reqOp0 = 4'd1; reqA0 = 16'd1; reqB0 = 16'd2;
        reqOp1 = 4'd3; reqA1 = 16'd2; reqB1 = 16'd3;
        pushExp(0, 4'd1, 16'd1, 16'd2);
        #1; nChecks++;
        if (reqReady !== 2'b01) $display("FAIL rm_lock ready=%b want 01", reqReady); else nPass++;
        @(negedge clk);
        rstN = 1'b0; reqValid = 2'b10; reqLock = 2'b00;
        #1; nChecks++;
        if ({rspValid, reqReady} !== 4'b0100) $display("FAIL rm_pending valid=%b ready=%b want 01/00", rspValid, reqReady);
        else nPass++;
        @(negedge clk);
        mFlags = 8'h00;
        #1; nChecks++;
        if ({rspValid, rspWb, lockErr, flagsQ, rspData0, rspFlags0} !== 37'h0)
            $display("FAIL rm_reset valid=%b wb=%b err=%b flags_q=%h d0=%h f0=%h want 0",
                     rspValid, rspWb, lockErr, flagsQ, rspData0, rspFlags0);
        else nPass++;
        rstN = 1'b1; reqValid = 2'b11;
        reqOp0 = 4'd10; reqA0 = 16'h00FF; reqB0 = 16'h0F0F;
        pushExp(0, 4'd10, 16'h00FF, 16'h0F0F);
        pushExp(1, 4'd3, 16'd2, 16'd3);
        #1; nChecks++;
        if (reqReady !== 2'b01) $display("FAIL rm_r0_wins ready=%b want 01", reqReady); else nPass++;
        @(negedge clk);
        reqValid = 2'b10;
        #1; nChecks++;
        if (reqReady !== 2'b10) $display("FAIL rm_r1_next ready=%b want 10", reqReady); else nPass++;
        @(negedge clk);
        reqValid = 2'b00;
        #1; nChecks++;
        if (flagsQ !== mFlags) $display("FAIL rm_flags flags_q=%h want %h", flagsQ, mFlags); else nPass++;
    endtask

    task automatic test_back_to_back_nops();
        @(negedge clk);
        reqValid = 2'b01; reqLock = 2'b00;
        reqOp0 = 4'd1; reqA0 = 16'h8000; reqB0 = 16'h8000;
        pushExp(0, 4'd1, 16'h8000, 16'h8000);
        #1; nChecks++;
        if (reqReady !== 2'b01) $display("FAIL nop_add ready=%b want 01", reqReady); else nPass++;
        for (int op = 11; op <= 15; op++) begin
            @(negedge clk);
            reqOp0 = 4'(op); reqA0 = 16'h1234; reqB0 = 16'h0F0F;
            pushExp(0, 4'(op), 16'h1234, 16'h0F0F);
            #1; nChecks++;
            if (reqReady !== 2'b01) $display("FAIL nop_ready op=%0d ready=%b want 01", op, reqReady); else nPass++;
        end
        @(negedge clk);
        reqValid = 2'b00;
        #1; nChecks++;
        if ({flagsQ, rspWb[0], rspData0} !== {8'h07, 1'b0, 16'h0000})
            $display("FAIL nop_state flags_q=%h wb0=%b d0=%h want 07/0/0000", flagsQ, rspWb[0], rspData0);
        else nPass++;
        nChecks++;
        if ({aluOp, aluA, aluB} !== 36'h0) $display("FAIL alu_idle op=%h a=%h b=%h want 0", aluOp, aluA, aluB);
        else nPass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock_chain();
        test_xor_nop();
        test_timeout();
        test_reset_midflight();
        test_back_to_back_nops();
        repeat (3) @(negedge clk);
        nChecks++;
        if (exp0.size() != 0 || exp1.size() != 0)
            $display("FAIL drain pending0=%0d pending1=%0d want 0/0", exp0.size(), exp1.size());
        else nPass++;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
